// File: rtl/host_write_controller.sv
// Host-side write controller: assembles R,G,B bytes from the host into 24-bit
// pixels and writes whole frames alternately into two display buffers.
module host_write_controller (
  input  logic        clock,
  input  logic        reset,
  input  logic        CSHost,
  input  logic [7:0]  DataIn,
  input  logic        DataValid,
  output logic        DataReady,
  input  logic [3:0]  AIPOut,
  input  logic [3:0]  AILOut,
  input  logic        Buf0Empty,
  input  logic        Buf1Empty,
  output logic        WE0,
  output logic        WE1,
  output logic [7:0]  WrAddr,
  output logic [23:0] WrData,
  output logic        Buf0Full,
  output logic        Buf1Full,
  output logic        ActiveBuf,
  output logic        FrameDone
);

  typedef enum logic [2:0] {IDLE, GET_R, GET_G, GET_B, WRITE, WAIT_BUF} state_t;

  state_t      state, next_state;
  logic [3:0]  aip_q, ail_q;
  logic [3:0]  px, line;
  logic [7:0]  addr;
  logic [7:0]  r_q, g_q, b_q;

  logic transfer;
  logic last_px, last_line, frame_end;
  logic other_full;
  logic set0, set1;

  // DataReady already implies CSHost was high last cycle; gating with the
  // current CSHost keeps a freshly deasserted chip select from accepting data.
  assign transfer   = CSHost && DataValid && DataReady;
  assign last_px    = (px == aip_q - 4'd1);
  assign last_line  = (line == ail_q - 4'd1);
  assign frame_end  = (state == WRITE) && last_px && last_line;
  assign other_full = ActiveBuf ? Buf0Full : Buf1Full;
  assign set0       = frame_end && !ActiveBuf;
  assign set1       = frame_end && ActiveBuf;

  // NOTE: next_state gets its default before the case so every path assigns
  // it and no latch is inferred.
  always_comb begin
    next_state = state;
    if (CSHost) begin
      case (state)
        IDLE:     if (AIPOut != 4'd0 && AILOut != 4'd0) next_state = GET_R;
        GET_R:    if (transfer) next_state = GET_G;
        GET_G:    if (transfer) next_state = GET_B;
        GET_B:    if (transfer) next_state = WRITE;
        WRITE:    if (frame_end) next_state = other_full ? WAIT_BUF : IDLE;
                  else           next_state = GET_R;
        WAIT_BUF: if (!other_full) next_state = IDLE;
        default:  next_state = IDLE;
      endcase
    end
  end

  // NOTE: all state here uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      DataReady <= 1'b0;
      WE0       <= 1'b0;
      WE1       <= 1'b0;
      WrAddr    <= 8'd0;
      WrData    <= 24'd0;
      Buf0Full  <= 1'b0;
      Buf1Full  <= 1'b0;
      ActiveBuf <= 1'b0;
      FrameDone <= 1'b0;
      aip_q     <= 4'd0;
      ail_q     <= 4'd0;
      px        <= 4'd0;
      line      <= 4'd0;
      addr      <= 8'd0;
      r_q       <= 8'd0;
      g_q       <= 8'd0;
      b_q       <= 8'd0;
    end else if (CSHost) begin
      state     <= next_state;
      DataReady <= (next_state == GET_R) || (next_state == GET_G) ||
                   (next_state == GET_B);
      WE0       <= (next_state == WRITE) && !ActiveBuf;
      WE1       <= (next_state == WRITE) && ActiveBuf;
      FrameDone <= frame_end;
      // Set wins over a coincident Empty pulse; a pulse on an empty buffer is a no-op.
      Buf0Full  <= set0 || (Buf0Full && !Buf0Empty);
      Buf1Full  <= set1 || (Buf1Full && !Buf1Empty);

      case (state)
        IDLE: begin
          if (AIPOut != 4'd0 && AILOut != 4'd0) begin
            aip_q <= AIPOut;
            ail_q <= AILOut;
            px    <= 4'd0;
            line  <= 4'd0;
            addr  <= 8'd0;
          end
        end
        GET_R: if (transfer) r_q <= DataIn;
        GET_G: if (transfer) g_q <= DataIn;
        GET_B: begin
          if (transfer) begin
            b_q    <= DataIn;
            WrData <= {r_q, g_q, DataIn};
            WrAddr <= addr;
          end
        end
        WRITE: begin
          if (frame_end) begin
            px   <= 4'd0;
            line <= 4'd0;
            addr <= 8'd0;
            if (!other_full) ActiveBuf <= ~ActiveBuf;
          end else begin
            addr <= addr + 8'd1;
            if (last_px) begin
              px   <= 4'd0;
              line <= line + 4'd1;
            end else begin
              px <= px + 4'd1;
            end
          end
        end
        WAIT_BUF: if (!other_full) ActiveBuf <= ~ActiveBuf;
        default: ;
      endcase
    end else begin
      DataReady <= 1'b0;
      WE0       <= 1'b0;
      WE1       <= 1'b0;
      FrameDone <= 1'b0;
    end
  end

endmodule
